// File: rtl/osc_pkg.sv
// Shared oscilloscope capture-path definitions: the capture FSM state type
// and the sample/record geometry used by this block and the snapshot copier.
package osc_pkg;

    localparam int SAMPLE_W     = 12;
    localparam int RECORD_DEPTH = 512;

    typedef enum logic [2:0] {
        FILL,
        ARMED,
        POST,
        HANDOFF,
        WAIT_COPY
    } capture_state_t;

    // Counter width able to hold the given terminal value, with one spare bit.
    function automatic int cnt_w(input int terminal);
        return $clog2(terminal) + 1;
    endfunction

endpackage

// File: rtl/trigger_capture_edge_detect.sv
// Combinational level-crossing compare between the previous and current
// accepted sample, unsigned, with rising/falling selection.
module edge_detect
    import osc_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W
) (
    input  logic [WIDTH-1:0] i_prev,
    input  logic             i_prev_ok,
    input  logic [WIDTH-1:0] i_cur,
    input  logic [WIDTH-1:0] i_level,
    input  logic             i_falling,
    output logic             o_cross
);

    logic w_rise;
    logic w_fall;

    always_comb begin
        w_rise  = (i_prev < i_level) && (i_cur >= i_level);
        w_fall  = (i_prev > i_level) && (i_cur <= i_level);
        o_cross = i_prev_ok && (i_falling ? w_fall : w_rise);
    end

endmodule

// File: rtl/trigger_capture.sv
// Acquisition front-end: shift window of ADC samples, level/auto trigger,
// pre/post-trigger record freeze and read/ready handoff to the copier.
module trigger_capture
    import osc_pkg::*;
#(
    parameter int DEPTH        = RECORD_DEPTH,
    parameter int WIDTH        = SAMPLE_W,
    parameter int PRE          = 128,
    parameter int AUTO_TIMEOUT = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] adc_data,
    input  logic             adc_valid,
    input  logic [WIDTH-1:0] trig_level,
    input  logic             trig_falling,
    input  logic             auto_mode,
    input  logic             ready,
    output logic             read,
    output logic [WIDTH-1:0] data [0:DEPTH-1],
    output logic             busy,
    output logic             forced
);

    localparam int POST_N = DEPTH - 1 - PRE;
    localparam int FILL_W = cnt_w(PRE);
    localparam int TO_W   = cnt_w(AUTO_TIMEOUT);
    localparam int POST_W = cnt_w(POST_N);

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PRE - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_TIMEOUT - 1);
    localparam logic [POST_W-1:0] POST_LAST = POST_W'(POST_N - 1);

    capture_state_t           r_state;
    logic [FILL_W-1:0]        r_fill_cnt;
    logic [TO_W-1:0]          r_to_cnt;
    logic [POST_W-1:0]        r_post_cnt;
    logic [WIDTH-1:0]         r_prev;
    logic                     r_prev_ok;
    logic [DEPTH*WIDTH-1:0]   r_buf;

    logic w_accept;
    logic w_cross;
    logic w_timeout;

    always_comb begin
        w_accept  = adc_valid && ((r_state == FILL) || (r_state == ARMED) || (r_state == POST));
        w_timeout = auto_mode && (r_to_cnt == TO_LAST);
    end

    edge_detect #(
        .WIDTH(WIDTH)
    ) u_edge (
        .i_prev   (r_prev),
        .i_prev_ok(r_prev_ok),
        .i_cur    (adc_data),
        .i_level  (trig_level),
        .i_falling(trig_falling),
        .o_cross  (w_cross)
    );

    // Window kept as one packed vector: element i lives at bits [i*WIDTH +: WIDTH],
    // so a shift toward index 0 is a single right shift by WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf <= '0;
        end else if (w_accept) begin
            r_buf <= {adc_data, r_buf[DEPTH*WIDTH-1:WIDTH]};
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_data
        assign data[g] = r_buf[g*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FILL;
            r_fill_cnt <= '0;
            r_to_cnt   <= '0;
            r_post_cnt <= '0;
            r_prev     <= '0;
            r_prev_ok  <= 1'b0;
            read       <= 1'b0;
            busy       <= 1'b0;
            forced     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_prev    <= adc_data;
                r_prev_ok <= 1'b1;
            end
            case (r_state)
                FILL: begin
                    if (adc_valid) begin
                        if (r_fill_cnt == FILL_LAST) begin
                            r_state  <= ARMED;
                            r_to_cnt <= '0;
                        end else begin
                            r_fill_cnt <= r_fill_cnt + FILL_W'(1);
                        end
                    end
                end
                ARMED: begin
                    // A real crossing takes priority over the auto timeout.
                    if (adc_valid) begin
                        if (w_cross) begin
                            r_state    <= POST;
                            r_post_cnt <= '0;
                            forced     <= 1'b0;
                        end else if (w_timeout) begin
                            r_state    <= POST;
                            r_post_cnt <= '0;
                            forced     <= 1'b1;
                        end else if (r_to_cnt != TO_LAST) begin
                            r_to_cnt <= r_to_cnt + TO_W'(1);
                        end
                    end
                end
                POST: begin
                    if (adc_valid) begin
                        if (r_post_cnt == POST_LAST) begin
                            r_state <= HANDOFF;
                            read    <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            r_post_cnt <= r_post_cnt + POST_W'(1);
                        end
                    end
                end
                HANDOFF: begin
                    if (!ready) begin
                        r_state <= WAIT_COPY;
                        read    <= 1'b0;
                    end
                end
                WAIT_COPY: begin
                    if (ready) begin
                        r_state    <= FILL;
                        r_fill_cnt <= '0;
                        r_to_cnt   <= '0;
                        r_post_cnt <= '0;
                        r_prev_ok  <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture: table of capture scenarios with
// hand-computed record values, plus reset and auto-disable sequences.
module tb_trigger_capture;

    logic        clk;
    logic        rst;
    logic [11:0] adc_data;
    logic        adc_valid;
    logic [11:0] trig_level;
    logic        trig_falling;
    logic        auto_mode;
    logic        ready;
    logic        read;
    logic [11:0] data [0:511];
    logic        busy;
    logic        forced;

    int errors = 0;
    int checks = 0;

    trigger_capture #(
        .DEPTH(512),
        .WIDTH(12),
        .PRE(128),
        .AUTO_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .adc_data(adc_data),
        .adc_valid(adc_valid),
        .trig_level(trig_level),
        .trig_falling(trig_falling),
        .auto_mode(auto_mode),
        .ready(ready),
        .read(read),
        .data(data),
        .busy(busy),
        .forced(forced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Copier model: ready drops one cycle after read is seen, returns 514 cycles later.
    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            if (read && ready) begin
                @(posedge clk); #2;
                ready = 1'b0;
                repeat (514) @(posedge clk);
                #2;
                ready = 1'b1;
            end
        end
    end

    typedef struct {
        string name;
        int    start;
        int    step;
        bit    falling;
        bit    stall;
        bit    auto_m;
        bit    exp_forced;
        int    trig_val;
        int    idx [4];
        int    exp [4];
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_capture(input int start, input int step, input bit stall,
                               input int budget, output bit got);
        int v = start;
        bit tog = 1'b0;
        got = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (read) begin
                got = 1'b1;
                adc_valid = 1'b0;
                break;
            end
            if (stall && tog) begin
                adc_valid = 1'b0;
            end else begin
                adc_valid = 1'b1;
                adc_data  = 12'(v);
                v += step;
            end
            tog = ~tog;
        end
        adc_valid = 1'b0;
    endtask

    // Entered at the negedge where read was first seen high.
    task automatic handshake(input string nm);
        logic [11:0] snap [0:511];
        int  rc = 1;
        int  bad = 0;
        bit  seen_low = 1'b0;
        bit  done = 1'b0;
        snap = data;
        for (int n = 0; n < 2000 && !done; n++) begin
            @(negedge clk);
            if (read) rc++;
            for (int k = 0; k < 512; k++) if (data[k] !== snap[k]) bad++;
            if (!ready) begin
                seen_low = 1'b1;
            end
            if (ready && seen_low) begin
                adc_valid = 1'b0;
                chk({nm, "_busy_copy_end"}, int'(busy), 1);
                @(negedge clk);
                chk({nm, "_rearm_busy"}, int'(busy), 0);
                done = 1'b1;
            end else begin
                adc_valid = 1'b1;
                adc_data  = 12'($urandom_range(0, 4095));
            end
        end
        adc_valid = 1'b0;
        chk({nm, "_handshake_done"}, int'(done), 1);
        chk({nm, "_read_cycles"}, rc, 2);
        chk({nm, "_data_frozen_bad"}, bad, 0);
    endtask

    task automatic run_vector(input int i, input string nm);
        bit got;
        int bad = 0;
        trig_level   = 12'd2048;
        trig_falling = vecs[i].falling;
        auto_mode    = vecs[i].auto_m;
        run_capture(vecs[i].start, vecs[i].step, vecs[i].stall, 3000, got);
        chk({nm, "_read"}, int'(got), 1);
        if (got) begin
            for (int j = 0; j < 4; j++)
                chk($sformatf("%s_data%0d", nm, vecs[i].idx[j]),
                    int'(data[vecs[i].idx[j]]), vecs[i].exp[j]);
            for (int k = 0; k < 512; k++)
                if (int'(data[k]) != vecs[i].trig_val + (k - 128) * vecs[i].step) bad++;
            chk({nm, "_record_bad"}, bad, 0);
            chk({nm, "_forced"}, int'(forced), int'(vecs[i].exp_forced));
            chk({nm, "_busy"}, int'(busy), 1);
            handshake(nm);
        end
    endtask

    task automatic mid_clock_reset();
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
    endtask

    initial begin
        bit got;
        int bad;
        vecs[0] = '{"rise", 0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 2048,
                    '{128, 127, 0, 511}, '{2048, 2044, 1536, 3580}};
        vecs[1] = '{"fall", 4092, -4, 1'b1, 1'b0, 1'b0, 1'b0, 2048,
                    '{128, 129, 0, 511}, '{2048, 2044, 2560, 516}};
        vecs[2] = '{"rise_stall", 0, 4, 1'b0, 1'b1, 1'b0, 1'b0, 2048,
                    '{128, 127, 0, 511}, '{2048, 2044, 1536, 3580}};
        vecs[3] = '{"auto", 100, 0, 1'b0, 1'b0, 1'b1, 1'b1, 100,
                    '{0, 128, 300, 511}, '{100, 100, 100, 100}};

        rst = 1'b1;
        adc_data = '0;
        adc_valid = 1'b0;
        trig_level = 12'd2048;
        trig_falling = 1'b0;
        auto_mode = 1'b0;
        #1;
        chk("reset_read", int'(read), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_forced", int'(forced), 0);
        chk("reset_data0", int'(data[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_read", int'(read), 0);
        chk("post_reset_busy", int'(busy), 0);

        for (int i = 0; i < 4; i++) run_vector(i, vecs[i].name);

        chk("pre_async_forced", int'(forced), 1);
        mid_clock_reset();
        chk("async_forced", int'(forced), 0);
        chk("async_read", int'(read), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_data0", int'(data[0]), 0);
        chk("async_data511", int'(data[511]), 0);
        @(negedge clk);
        rst = 1'b0;

        trig_level = 12'd2048;
        trig_falling = 1'b0;
        auto_mode = 1'b0;
        run_capture(100, 0, 1'b0, 10000, got);
        chk("noauto_no_read", int'(got), 0);
        chk("noauto_busy", int'(busy), 0);

        mid_clock_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 613; n++) begin
            @(negedge clk);
            adc_valid = 1'b1;
            adc_data  = 12'(n * 4);
        end
        @(negedge clk);
        adc_valid = 1'b0;
        chk("post_phase_read", int'(read), 0);
        chk("post_phase_data511", int'(data[511]), 2448);
        mid_clock_reset();
        bad = 0;
        for (int k = 0; k < 512; k++) if (data[k] !== 12'd0) bad++;
        chk("post_rst_nonzero", bad, 0);
        chk("post_rst_read", int'(read), 0);
        chk("post_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        run_vector(0, "rise_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
